// File: rtl/recompute_output_merger_os_pkg.sv
// Shared types and default geometry for the OS recompute output merger.
package recompute_output_merger_os_pkg;

  typedef enum logic [1:0] {
    MRG_IDLE    = 2'd0,
    MRG_COLLECT = 2'd1,
    MRG_MERGE   = 2'd2,
    MRG_STREAM  = 2'd3
  } mrg_state_e;

  localparam int DEF_ROWS           = 4;
  localparam int DEF_COLS           = 4;
  localparam int DEF_WORD_SIZE      = 16;
  localparam int DEF_NUM_RU         = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/recompute_output_merger_os_ru_result_capture.sv
// Per-RU result register and capture flag; a fresh pulse beats the merge-time clear
// so results arriving during MERGE carry over to the next job.
module recompute_output_merger_os_ru_result_capture #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pulse,
  input  logic                 ignore,
  input  logic                 clr,
  input  logic [WORD_SIZE-1:0] data,
  output logic                 cap,
  output logic [WORD_SIZE-1:0] result
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap    <= 1'b0;
      result <= '0;
    end else if (pulse && !ignore) begin
      cap    <= 1'b1;
      result <= data;
    end else if (clr) begin
      cap <= 1'b0;
    end
  end

endmodule

// File: rtl/recompute_output_merger_os.sv
// Substitutes recompute-unit results into the OS result matrix at faulty PE
// coordinates and streams the corrected matrix out row by row.
module recompute_output_merger_os
  import recompute_output_merger_os_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int WORD_SIZE      = DEF_WORD_SIZE,
  parameter int NUM_RU         = DEF_NUM_RU,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            array_done,
  input  logic [ROWS*COLS*WORD_SIZE-1:0]  array_result,
  input  logic [ROWS*COLS-1:0]            STW_result_mat,
  input  logic [NUM_RU-1:0]               ru_en,
  input  logic [CW*NUM_RU-1:0]            ru_col_mapping,
  input  logic [RW*NUM_RU-1:0]            ru_row_mapping,
  input  logic [NUM_RU-1:0]               ru_output_valid,
  input  logic [NUM_RU*WORD_SIZE-1:0]     ru_result,
  output logic [COLS*WORD_SIZE-1:0]       out_row_data,
  output logic [RW-1:0]                   out_row_idx,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            done,
  output logic                            uncorrectable
);

  localparam int NPE = ROWS * COLS;
  localparam int IW  = $clog2(NPE);
  localparam int ZW  = $clog2(NPE) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [ZW-1:0] NRU_Z    = ZW'(NUM_RU);

  mrg_state_e state, state_nxt;

  logic [WORD_SIZE-1:0] mat     [NPE];
  logic [WORD_SIZE-1:0] merged  [NPE];
  logic [WORD_SIZE-1:0] ru_word [NUM_RU];
  logic [RW-1:0]        row_q   [NUM_RU];
  logic [CW-1:0]        col_q   [NUM_RU];
  logic [NUM_RU-1:0]    en_q, cap, ignore;
  logic [ZW-1:0]        zero_cnt, zero_cnt_q;
  logic [TW-1:0]        to_cnt;
  logic [RW-1:0]        rowcnt;
  logic                 timeout_q;
  logic                 start, collect_done, to_hit, xfer, last_xfer, merge_clr;
  logic [IW-1:0]        widx, ridx;

  assign start        = (state == MRG_IDLE) && array_done;
  assign collect_done = ((cap | ru_output_valid) & en_q) == en_q;
  assign to_hit       = (to_cnt == TO_LAST);
  assign out_valid    = (state == MRG_STREAM);
  assign xfer         = out_valid && out_ready;
  assign last_xfer    = xfer && (rowcnt == ROW_LAST);
  assign merge_clr    = (state == MRG_MERGE);
  assign ignore       = (state == MRG_COLLECT) ? ~en_q : '0;
  assign out_row_idx  = out_valid ? rowcnt : '0;
  assign uncorrectable = timeout_q || (zero_cnt_q > NRU_Z);

  for (genvar i = 0; i < NUM_RU; i++) begin : g_cap
    recompute_output_merger_os_ru_result_capture #(.WORD_SIZE(WORD_SIZE)) u_ru_result_capture (
      .clk    (clk),
      .rst    (rst),
      .pulse  (ru_output_valid[i]),
      .ignore (ignore[i]),
      .clr    (merge_clr),
      .data   (ru_result[i*WORD_SIZE +: WORD_SIZE]),
      .cap    (cap[i]),
      .result (ru_word[i])
    );
  end

  always_comb begin
    zero_cnt = '0;
    for (int k = 0; k < NPE; k++) zero_cnt = zero_cnt + ZW'(!STW_result_mat[k]);
  end

  // Walk RUs from highest to lowest index so the lowest index lands last and wins.
  always_comb begin
    widx = '0;
    for (int k = 0; k < NPE; k++) merged[k] = mat[k];
    for (int i = NUM_RU - 1; i >= 0; i--) begin
      widx = IW'(int'(row_q[i]) * COLS + int'(col_q[i]));
      if (en_q[i] && cap[i] && (int'(row_q[i]) < ROWS) && (int'(col_q[i]) < COLS))
        merged[widx] = ru_word[i];
    end
  end

  always_comb begin
    out_row_data = '0;
    ridx         = '0;
    for (int c = 0; c < COLS; c++) begin
      ridx = IW'(int'(rowcnt) * COLS + c);
      if (out_valid) out_row_data[c*WORD_SIZE +: WORD_SIZE] = mat[ridx];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MRG_IDLE:    if (array_done) state_nxt = MRG_COLLECT;
      MRG_COLLECT: if (collect_done || to_hit) state_nxt = MRG_MERGE;
      MRG_MERGE:   state_nxt = MRG_STREAM;
      MRG_STREAM:  if (last_xfer) state_nxt = MRG_IDLE;
      default:     state_nxt = MRG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MRG_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NPE; k++) mat[k] <= '0;
      for (int i = 0; i < NUM_RU; i++) begin
        row_q[i] <= '0;
        col_q[i] <= '0;
      end
      en_q       <= '0;
      zero_cnt_q <= '0;
      timeout_q  <= 1'b0;
      to_cnt     <= '0;
      rowcnt     <= '0;
      done       <= 1'b0;
    end else begin
      done <= last_xfer;
      if (start) begin
        for (int k = 0; k < NPE; k++) mat[k] <= array_result[k*WORD_SIZE +: WORD_SIZE];
        for (int i = 0; i < NUM_RU; i++) begin
          row_q[i] <= ru_row_mapping[i*RW +: RW];
          col_q[i] <= ru_col_mapping[i*CW +: CW];
        end
        en_q       <= ru_en;
        zero_cnt_q <= zero_cnt;
        timeout_q  <= 1'b0;
        to_cnt     <= '0;
      end
      if (state == MRG_COLLECT) begin
        if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
        if (to_hit && !collect_done) timeout_q <= 1'b1;
      end
      if (state == MRG_MERGE) begin
        for (int k = 0; k < NPE; k++) mat[k] <= merged[k];
        rowcnt <= '0;
      end else if (xfer) begin
        rowcnt <= rowcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_recompute_output_merger_os.sv
// Directed-vector bench for the OS recompute output merger.
module tb_recompute_output_merger_os;

  logic          clk = 1'b0;
  logic          rst;
  logic          array_done;
  logic [255:0]  array_result;
  logic [15:0]   STW_result_mat;
  logic [3:0]    ru_en;
  logic [7:0]    ru_col_mapping;
  logic [7:0]    ru_row_mapping;
  logic [3:0]    ru_output_valid;
  logic [63:0]   ru_result;
  logic [63:0]   out_row_data;
  logic [1:0]    out_row_idx;
  logic          out_valid;
  logic          out_ready;
  logic          done;
  logic          uncorrectable;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_mat [16];

  always #5 clk = ~clk;

  recompute_output_merger_os dut (
    .clk             (clk),
    .rst             (rst),
    .array_done      (array_done),
    .array_result    (array_result),
    .STW_result_mat  (STW_result_mat),
    .ru_en           (ru_en),
    .ru_col_mapping  (ru_col_mapping),
    .ru_row_mapping  (ru_row_mapping),
    .ru_output_valid (ru_output_valid),
    .ru_result       (ru_result),
    .out_row_data    (out_row_data),
    .out_row_idx     (out_row_idx),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .done            (done),
    .uncorrectable   (uncorrectable)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_row(input int r);
    logic [63:0] v;
    for (int c = 0; c < 4; c++) v[c*16 +: 16] = exp_mat[r*4 + c];
    return v;
  endfunction

  task automatic set_matrix(input logic [15:0] off);
    for (int k = 0; k < 16; k++) begin
      array_result[k*16 +: 16] = off + 16'(k);
      exp_mat[k]               = off + 16'(k);
    end
    STW_result_mat = 16'hFFFF;
    ru_en          = 4'b0000;
    ru_row_mapping = '0;
    ru_col_mapping = '0;
  endtask

  task automatic map_ru(input int i, input logic [1:0] r, input logic [1:0] c);
    ru_row_mapping[i*2 +: 2] = r;
    ru_col_mapping[i*2 +: 2] = c;
  endtask

  task automatic start_job();
    array_done = 1'b1;
    step();
    array_done = 1'b0;
  endtask

  task automatic pulse_ru(input logic [3:0] mask, input logic [15:0] val);
    ru_output_valid = mask;
    for (int i = 0; i < 4; i++) ru_result[i*16 +: 16] = val;
    step();
    ru_output_valid = '0;
  endtask

  task automatic drain(input bit bp);
    int          row = 0;
    int          cyc = 0;
    bit          stalled = 0;
    logic [63:0] held_d = '0;
    logic [1:0]  held_i = '0;
    while (row < 4 && cyc < 300) begin
      out_ready = bp ? cyc[0] : 1'b1;
      if (out_valid) begin
        if (stalled) begin
          check("hold_data", out_row_data, held_d);
          check("hold_idx", 64'(out_row_idx), 64'(held_i));
        end
        if (out_ready) begin
          check("row_idx", 64'(out_row_idx), 64'(row));
          check("row_data", out_row_data, exp_row(row));
          row++;
          stalled = 0;
        end else begin
          stalled = 1;
          held_d  = out_row_data;
          held_i  = out_row_idx;
        end
      end
      step();
      cyc++;
    end
    out_ready = 1'b1;
    check("rows_streamed", 64'(row), 64'd4);
    check("done_pulse", 64'(done), 64'd1);
    check("valid_drop", 64'(out_valid), 64'd0);
    step();
    check("done_single", 64'(done), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b0;
    array_done      = 1'b0;
    array_result    = '0;
    ru_output_valid = '0;
    ru_result       = '0;
    out_ready       = 1'b1;
    set_matrix(16'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_unc", 64'(uncorrectable), 64'd0);
    check("rst_data", out_row_data, 64'd0);
    check("rst_idx", 64'(out_row_idx), 64'd0);
    rst = 1'b1;
    step();

    // no faults
    set_matrix(16'h0);
    start_job();
    drain(0);
    check("nofault_unc", 64'(uncorrectable), 64'd0);

    // single fault at (2,1), stray array_done mid-job must be ignored
    set_matrix(16'h0);
    STW_result_mat[9] = 1'b0;
    ru_en = 4'b0001;
    map_ru(0, 2'd2, 2'd1);
    start_job();
    array_result = {16{16'hDEAD}};
    array_done   = 1'b1;
    step();
    array_done   = 1'b0;
    repeat (2) step();
    pulse_ru(4'b0001, 16'hBEEF);
    check("lat_merge", 64'(out_valid), 64'd0);
    step();
    check("lat_first", 64'(out_valid), 64'd1);
    exp_mat[9] = 16'hBEEF;
    drain(0);
    check("onefault_unc", 64'(uncorrectable), 64'd0);

    // timeout: RU0 and RU1 enabled, only RU1 reports
    set_matrix(16'h20);
    STW_result_mat[0] = 1'b0;
    STW_result_mat[7] = 1'b0;
    ru_en = 4'b0011;
    map_ru(0, 2'd0, 2'd0);
    map_ru(1, 2'd1, 2'd3);
    start_job();
    pulse_ru(4'b0010, 16'hCAFE);
    repeat (62) step();
    check("to_early_unc", 64'(uncorrectable), 64'd0);
    check("to_early_valid", 64'(out_valid), 64'd0);
    step();
    check("to_unc", 64'(uncorrectable), 64'd1);
    check("to_merge_valid", 64'(out_valid), 64'd0);
    exp_mat[7] = 16'hCAFE;
    drain(0);
    check("to_unc_held", 64'(uncorrectable), 64'd1);

    // zero-count overflow plus RU0/RU2 collision at (0,0)
    set_matrix(16'h30);
    STW_result_mat = 16'hFFE0;
    ru_en = 4'b0101;
    map_ru(0, 2'd0, 2'd0);
    map_ru(2, 2'd0, 2'd0);
    start_job();
    check("ovf_unc", 64'(uncorrectable), 64'd1);
    ru_output_valid = 4'b0101;
    ru_result       = {16'h0, 16'h2222, 16'h0, 16'h1111};
    step();
    ru_output_valid = '0;
    exp_mat[0] = 16'h1111;
    drain(0);

    // backpressure on alternate cycles; uncorrectable clears on the new job
    set_matrix(16'h40);
    start_job();
    check("bp_unc_clear", 64'(uncorrectable), 64'd0);
    drain(1);

    // reset in the middle of streaming
    set_matrix(16'h80);
    start_job();
    for (int n = 0; n < 20 && !out_valid; n++) step();
    check("rs_row0", 64'(out_row_idx), 64'd0);
    step();
    check("rs_row1", 64'(out_row_idx), 64'd1);
    step();
    rst = 1'b0;
    #1;
    check("rs_valid", 64'(out_valid), 64'd0);
    check("rs_idx", 64'(out_row_idx), 64'd0);
    check("rs_data", out_row_data, 64'd0);
    check("rs_done", 64'(done), 64'd0);
    #3;
    rst = 1'b1;
    step();

    // RU pulse while idle is kept and satisfies the next job immediately
    set_matrix(16'h100);
    STW_result_mat[14] = 1'b0;
    ru_en = 4'b1000;
    map_ru(3, 2'd3, 2'd2);
    pulse_ru(4'b1000, 16'h7777);
    repeat (2) step();
    start_job();
    step();
    check("idle_cap_merge", 64'(out_valid), 64'd0);
    exp_mat[14] = 16'h7777;
    drain(0);
    check("idle_cap_unc", 64'(uncorrectable), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
